// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU op codes, result classes and IEEE-754 constants
package fpu_pkg;

   typedef enum logic [1:0] {
      FPU_OP_ADD = 2'b00,
      FPU_OP_SUB = 2'b01,
      FPU_OP_MUL = 2'b10,
      FPU_OP_DIV = 2'b11
   } fpu_op_t;

   typedef enum logic [1:0] {
      FPU_CLS_NORMAL = 2'b00,
      FPU_CLS_ZERO   = 2'b01,
      FPU_CLS_INF    = 2'b10,
      FPU_CLS_NAN    = 2'b11
   } fpu_cls_t;

   localparam logic [7:0]  EXP_MAX = 8'hFF;
   localparam logic [31:0] QNAN    = 32'h7FC00000;

endpackage

// File: rtl/fpu_classify.sv
// rtl/fpu_classify.sv - combinational IEEE-754 single class decode
module fpu_classify
   import fpu_pkg::*;
(
   input  logic [31:0] value,
   output logic [1:0]  cls
);

   logic [7:0]  exp_f;
   logic [22:0] frac_f;

   assign exp_f  = value[30:23];
   assign frac_f = value[22:0];

   // Denormals fold into zero because the arithmetic units flush them.
   always_comb begin
      cls = FPU_CLS_NORMAL;
      if (exp_f == EXP_MAX) begin
         cls = (frac_f != 23'd0) ? FPU_CLS_NAN : FPU_CLS_INF;
      end else if (exp_f == 8'd0) begin
         cls = FPU_CLS_ZERO;
      end
   end

endmodule

// File: rtl/fpu_result_queue.sv
// rtl/fpu_result_queue.sv - in-order FPU writeback FIFO with sticky exception flags
module fpu_result_queue
   import fpu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [1:0]                 in_op,
   input  logic [TAG_W-1:0]           in_tag,
   input  logic [31:0]                in_result,
   input  logic                       in_error,
   input  logic                       in_overflow,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [1:0]                 out_op,
   output logic [TAG_W-1:0]           out_tag,
   output logic [31:0]                out_result,
   output logic                       out_error,
   output logic                       out_overflow,
   output logic [1:0]                 out_class,
   output logic [$clog2(DEPTH):0]     count,
   input  logic                       flag_clr,
   output logic                       sticky_err,
   output logic                       sticky_ovf
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [1:0]       op_mem  [DEPTH];
   logic [TAG_W-1:0] tag_mem [DEPTH];
   logic [31:0]      res_mem [DEPTH];
   logic             err_mem [DEPTH];
   logic             ovf_mem [DEPTH];

   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             push;
   logic             pop;

   // Ready/valid come from registered occupancy only, never from out_ready.
   assign in_ready  = (count != FULL_CNT);
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         sticky_err <= 1'b0;
         sticky_ovf <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
         sticky_err <= (sticky_err & ~flag_clr) | (push & in_error);
         sticky_ovf <= (sticky_ovf & ~flag_clr) | (push & in_overflow);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !reset) begin
         op_mem[wr_ptr]  <= in_op;
         tag_mem[wr_ptr] <= in_tag;
         res_mem[wr_ptr] <= in_result;
         err_mem[wr_ptr] <= in_error;
         ovf_mem[wr_ptr] <= in_overflow;
      end
   end

   assign out_op       = op_mem[rd_ptr];
   assign out_tag      = tag_mem[rd_ptr];
   assign out_result   = res_mem[rd_ptr];
   assign out_error    = err_mem[rd_ptr];
   assign out_overflow = ovf_mem[rd_ptr];

   fpu_classify u_classify (
      .value (out_result),
      .cls   (out_class)
   );

endmodule

// File: tb/tb_fpu_result_queue.sv
// tb/tb_fpu_result_queue.sv - scoreboard bench for fpu_result_queue
module tb_fpu_result_queue;

   typedef struct {
      logic [1:0]  op;
      logic [3:0]  tag;
      logic [31:0] result;
      logic        err;
      logic        ovf;
   } entry_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [3:0]  in_tag;
   logic [31:0] in_result;
   logic        in_error;
   logic        in_overflow;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_op;
   logic [3:0]  out_tag;
   logic [31:0] out_result;
   logic        out_error;
   logic        out_overflow;
   logic [1:0]  out_class;
   logic [2:0]  count;
   logic        flag_clr;
   logic        sticky_err;
   logic        sticky_ovf;

   int     errors = 0;
   int     checks = 0;
   entry_t sb[$];
   entry_t e;

   fpu_result_queue #(.DEPTH(4), .TAG_W(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_op        (in_op),
      .in_tag       (in_tag),
      .in_result    (in_result),
      .in_error     (in_error),
      .in_overflow  (in_overflow),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_op       (out_op),
      .out_tag      (out_tag),
      .out_result   (out_result),
      .out_error    (out_error),
      .out_overflow (out_overflow),
      .out_class    (out_class),
      .count        (count),
      .flag_clr     (flag_clr),
      .sticky_err   (sticky_err),
      .sticky_ovf   (sticky_ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic v, input logic [1:0] op, input logic [3:0] tag,
                         input logic [31:0] res, input logic er, input logic ov);
      in_valid    = v;
      in_op       = op;
      in_tag      = tag;
      in_result   = res;
      in_error    = er;
      in_overflow = ov;
   endtask

   task automatic expect_push(input logic [1:0] op, input logic [3:0] tag,
                              input logic [31:0] res, input logic er, input logic ov);
      entry_t n;
      set_in(1'b1, op, tag, res, er, ov);
      n.op = op; n.tag = tag; n.result = res; n.err = er; n.ovf = ov;
      sb.push_back(n);
   endtask

   task automatic test_reset();
      reset = 1'b1; out_ready = 1'b0; flag_clr = 1'b0;
      set_in(1'b0, 2'b00, 4'h0, 32'h0, 1'b0, 1'b0);
      tick(); tick();
      reset = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (sticky_err !== 1'b0) begin errors++; $display("FAIL reset_sticky_err got=%b exp=0", sticky_err); end
      checks++; if (sticky_ovf !== 1'b0) begin errors++; $display("FAIL reset_sticky_ovf got=%b exp=0", sticky_ovf); end
   endtask

   task automatic test_single_push();
      out_ready = 1'b0;
      expect_push(2'b11, 4'd3, 32'h40400000, 1'b0, 1'b0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass got=%b exp=0", out_valid); end
      tick();
      set_in(1'b0, 2'b00, 4'hF, 32'hFFFFFFFF, 1'b1, 1'b1);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", count); end
      checks++; if (out_class !== 2'b00) begin errors++; $display("FAIL single_class got=%b exp=00", out_class); end
      tick();
      e = sb.pop_front();
      checks++; if (out_tag !== e.tag) begin errors++; $display("FAIL single_tag_stable got=%0d exp=%0d", out_tag, e.tag); end
      checks++; if (out_result !== e.result) begin errors++; $display("FAIL single_result got=%h exp=%h", out_result, e.result); end
      checks++; if (out_op !== e.op) begin errors++; $display("FAIL single_op got=%b exp=%b", out_op, e.op); end
      checks++; if (sticky_err !== 1'b0) begin errors++; $display("FAIL single_idle_flags got=%b exp=0", sticky_err); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drained got=%b exp=0", out_valid); end
   endtask

   task automatic test_fill_and_drain();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         expect_push(2'(i), 4'(i), 32'h3F800000 + 32'(i), 1'b0, 1'b0);
         tick();
      end
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", count); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
      set_in(1'b1, 2'b01, 4'd9, 32'h12345678, 1'b1, 1'b1);
      tick();
      set_in(1'b0, 2'b00, 4'h0, 32'h0, 1'b0, 1'b0);
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_fifth_ignored got=%0d exp=4", count); end
      checks++; if (sticky_err !== 1'b0 || sticky_ovf !== 1'b0) begin errors++; $display("FAIL fill_fifth_flags got=%b%b exp=00", sticky_err, sticky_ovf); end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         e = sb.pop_front();
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d] got=%b exp=1", i, out_valid); end
         checks++; if (out_tag !== e.tag || out_result !== e.result || out_op !== e.op) begin
            errors++; $display("FAIL drain_entry[%0d] got=%0d/%h/%b exp=%0d/%h/%b", i, out_tag, out_result, out_op, e.tag, e.result, e.op);
         end
         tick();
      end
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL drain_empty got=%b/%0d exp=0/0", out_valid, count); end
   endtask

   task automatic test_full_simultaneous();
      out_ready = 1'b0;
      for (int i = 4; i < 8; i++) begin
         expect_push(2'b10, 4'(i), 32'h41000000 + 32'(i), 1'b0, 1'b0);
         tick();
      end
      set_in(1'b1, 2'b10, 4'd8, 32'h41000008, 1'b0, 1'b0);
      out_ready = 1'b1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready_no_comb got=%b exp=0", in_ready); end
      e = sb.pop_front();
      checks++; if (out_tag !== e.tag) begin errors++; $display("FAIL full_pop_tag got=%0d exp=%0d", out_tag, e.tag); end
      tick();
      set_in(1'b0, 2'b00, 4'h0, 32'h0, 1'b0, 1'b0);
      out_ready = 1'b0;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready_next got=%b exp=1", in_ready); end
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_count got=%0d exp=3", count); end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         e = sb.pop_front();
         checks++; if (out_valid !== 1'b1 || out_tag !== e.tag) begin
            errors++; $display("FAIL full_drain[%0d] got=%b/%0d exp=1/%0d", i, out_valid, out_tag, e.tag);
         end
         tick();
      end
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_drain_empty got=%b exp=0", out_valid); end
   endtask

   task automatic test_class_and_sticky();
      out_ready = 1'b0;
      expect_push(2'b11, 4'd1, 32'h7FC00000, 1'b1, 1'b0);
      tick();
      expect_push(2'b10, 4'd2, 32'h7F800000, 1'b0, 1'b1);
      tick();
      set_in(1'b0, 2'b00, 4'h0, 32'h0, 1'b0, 1'b0);
      checks++; if (sticky_err !== 1'b1) begin errors++; $display("FAIL sticky_err_set got=%b exp=1", sticky_err); end
      checks++; if (sticky_ovf !== 1'b1) begin errors++; $display("FAIL sticky_ovf_set got=%b exp=1", sticky_ovf); end
      out_ready = 1'b1;
      e = sb.pop_front();
      checks++; if (out_class !== 2'b11 || out_error !== e.err) begin errors++; $display("FAIL class_nan got=%b/%b exp=11/%b", out_class, out_error, e.err); end
      tick();
      e = sb.pop_front();
      checks++; if (out_class !== 2'b10 || out_overflow !== e.ovf) begin errors++; $display("FAIL class_inf got=%b/%b exp=10/%b", out_class, out_overflow, e.ovf); end
      tick();
      out_ready = 1'b0;
      expect_push(2'b00, 4'd5, 32'h00000001, 1'b1, 1'b0);
      flag_clr = 1'b1;
      tick();
      flag_clr = 1'b0;
      set_in(1'b0, 2'b00, 4'h0, 32'h0, 1'b0, 1'b0);
      checks++; if (sticky_err !== 1'b1) begin errors++; $display("FAIL clr_set_wins got=%b exp=1", sticky_err); end
      checks++; if (sticky_ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf got=%b exp=0", sticky_ovf); end
      checks++; if (out_class !== 2'b01) begin errors++; $display("FAIL class_denorm_zero got=%b exp=01", out_class); end
      flag_clr = 1'b1;
      tick();
      flag_clr = 1'b0;
      checks++; if (sticky_err !== 1'b0) begin errors++; $display("FAIL clr_only got=%b exp=0", sticky_err); end
      out_ready = 1'b1;
      e = sb.pop_front();
      checks++; if (out_tag !== e.tag || out_error !== e.err) begin errors++; $display("FAIL clr_entry got=%0d/%b exp=%0d/%b", out_tag, out_error, e.tag, e.err); end
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      expect_push(2'b00, 4'd0, 32'h3F800000, 1'b0, 1'b0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty_no_pop got=%b exp=0", out_valid); end
      tick();
      for (int i = 1; i <= 20; i++) begin
         checks++; if (count !== 3'd1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_count[%0d] got=%0d/%b exp=1/1", i, count, out_valid);
         end
         e = sb.pop_front();
         checks++; if (out_tag !== e.tag || out_result !== e.result) begin
            errors++; $display("FAIL b2b_tag[%0d] got=%0d/%h exp=%0d/%h", i, out_tag, out_result, e.tag, e.result);
         end
         expect_push(2'(i), 4'(i), 32'h3F800000 + 32'(i << 8), 1'b0, 1'b0);
         tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sb.delete();
      checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_reset got=%0d/%b exp=0/0", count, out_valid); end
      set_in(1'b0, 2'b00, 4'h0, 32'h0, 1'b0, 1'b0);
      out_ready = 1'b0;
      tick();
      checks++; if (count !== 3'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_post_reset got=%0d/%b exp=0/1", count, in_ready); end
   endtask

   initial begin
      test_reset();
      test_single_push();
      test_fill_and_drain();
      test_full_simultaneous();
      test_class_and_sticky();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
